ias_fetch_unit: RTL

- Upstream instruction-fetch stage for the IAS datapath.
- Reads 32-bit instruction words from instruction memory. Each word packs a left and a right instruction, each an 8-bit opcode plus an 8-bit address.
- Holds the right instruction in an instruction buffer register (IBR) and issues opcode/address pairs one at a time to the control unit / datapath over a valid/ready handshake.
- Owns the program counter; accepts branch redirects from downstream.

---
 rtl/ias_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ias_fetch_unit.sv
// IAS instruction fetch: reads packed left/right instruction words, buffers the right half in the IBR
// and issues opcode/address pairs over valid/ready. Optional macro SKIP_NOP_EN drops left-half NOPs.
module ias_fetch_unit #(
    parameter int  ADDR_W = 8,
    parameter int  OP_W   = 8,
    localparam int WORD_W = 2 * (OP_W + ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] address,
    output logic              issue_right,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              branch_right,
    output logic [1:0]        dbg_state
);

    // Handshake: an instruction transfers on a rising edge where issue_valid && issue_ready;
    // while valid is high and ready is low, opcode/address/issue_right/pc_out hold stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   ibr_op;
    logic [ADDR_W-1:0] ibr_addr;
    logic              start_right;
    logic              handshake;
    logic              skip_left;
    logic              take_right_first;

    logic [OP_W-1:0]   l_op, r_op;
    logic [ADDR_W-1:0] l_addr, r_addr;

    assign l_op   = mem_rdata[WORD_W-1 -: OP_W];
    assign l_addr = mem_rdata[OP_W+2*ADDR_W-1 -: ADDR_W];
    assign r_op   = mem_rdata[OP_W+ADDR_W-1 -: OP_W];
    assign r_addr = mem_rdata[ADDR_W-1:0];

`ifdef SKIP_NOP_EN
    assign skip_left = (l_op == '0);
`else
    assign skip_left = 1'b0;
`endif

    assign take_right_first = start_right | skip_left;
    assign mem_req          = (state == FETCH);
    assign mem_addr         = pc;
    assign issue_valid      = (state == LEFT) || (state == RIGHT);
    assign handshake        = issue_valid & issue_ready;
    assign dbg_state        = state;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = FETCH;
            FETCH:   if (mem_ack) state_d = take_right_first ? RIGHT : LEFT;
            LEFT:    if (handshake) state_d = RIGHT;
            RIGHT:   if (handshake) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        // A redirect overrides everything, including a same-cycle ack or handshake.
        if (branch_valid) state_d = FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            ibr_op      <= '0;
            ibr_addr    <= '0;
            start_right <= 1'b0;
            opcode      <= '0;
            address     <= '0;
            issue_right <= 1'b0;
            pc_out      <= '0;
        end else begin
            state <= state_d;
            if (branch_valid) begin
                pc          <= branch_target;
                start_right <= branch_right;
                ibr_op      <= '0;
                ibr_addr    <= '0;
            end else begin
                case (state)
                    FETCH: begin
                        if (mem_ack) begin
                            pc_out      <= pc;
                            pc          <= pc + 1'b1;
                            ibr_op      <= r_op;
                            ibr_addr    <= r_addr;
                            start_right <= 1'b0;
                            if (take_right_first) begin
                                opcode      <= r_op;
                                address     <= r_addr;
                                issue_right <= 1'b1;
                            end else begin
                                opcode      <= l_op;
                                address     <= l_addr;
                                issue_right <= 1'b0;
                            end
                        end
                    end
                    LEFT: begin
                        if (handshake) begin
                            opcode      <= ibr_op;
                            address     <= ibr_addr;
                            issue_right <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
